// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN classifier top level.
// The UART transmitter uses the state enum, baud divider and frame length from here.
`timescale 1ns/1ps
package cnn_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } uart_tx_state_t;

    localparam int UART_BAUD_DIV   = 434;
    localparam int UART_FRAME_BITS = 10;

    // 8N1 frame as it sits in the shift register: bit 0 leaves the pin first.
    function automatic logic [UART_FRAME_BITS-1:0] uart_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one frame per accepted trmt, sticky tx_done when the stop bit ends.
// Handshake: trmt is accepted only in IDLE; tx_done stays high until the next accepted trmt.
`timescale 1ns/1ps
module uart_tx
    import cnn_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam int                  CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0]    BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]          LAST_BIT  = 4'(UART_FRAME_BITS - 1);

    uart_tx_state_t               state_q, state_d;
    logic [UART_FRAME_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]             baud_cnt_q, baud_cnt_d;
    logic [3:0]                   bit_cnt_q, bit_cnt_d;
    logic                         tx_done_q, tx_done_d;
    logic                         baud_tick;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_done_d  = tx_done_q;
        baud_tick  = (state_q == TRANSMIT) && (baud_cnt_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                if (trmt) begin
                    shift_d    = uart_frame(tx_data);
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_done_d  = 1'b0;
                    state_d    = TRANSMIT;
                end
            end
            TRANSMIT: begin
                if (baud_tick) begin
                    // The last shift empties the frame, leaving all ones so TX idles high.
                    baud_cnt_d = '0;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    shift_d    = {1'b1, shift_q[UART_FRAME_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        tx_done_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign TX      = shift_q[0];
    assign tx_done = tx_done_q;

endmodule
